// File: rtl/tx_resp_sched_pkg.sv
// Shared definitions for the TX response scheduler.
// Macro TX_ALU_HIGH_BYTE_EN: when defined, ALU responses carry two bytes
// (ALU_OUT[7:0] then ALU_OUT[15:8]); otherwise one byte and the ALU slot
// stores only the low byte.
package tx_resp_sched_pkg;

    localparam int unsigned TMO_CYCLES_DEFAULT = 8;
    localparam int unsigned RF_SLOT_W          = 8;

`ifdef TX_ALU_HIGH_BYTE_EN
    localparam int unsigned ALU_SLOT_W   = 16;
    localparam bit          ALU_TWO_BYTE = 1'b1;
`else
    localparam int unsigned ALU_SLOT_W   = 8;
    localparam bit          ALU_TWO_BYTE = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    typedef enum logic {
        SRC_RF  = 1'b0,
        SRC_ALU = 1'b1
    } src_e;

    // Response latched at grant time; the slot is free to refill afterwards.
    typedef struct packed {
        logic [15:0] data;
        logic        two_byte;
    } resp_t;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_RF) ? SRC_ALU : SRC_RF;
    endfunction

endpackage

// File: rtl/tx_resp_sched_slot.sv
// Single pending-response slot: occupied bit, data register, overflow detect.
// Ports:
//   clk, rst      - clock, async active-high reset
//   vld, data_in  - source strobe and its payload
//   consume       - scheduler takes the slot this cycle
//   occupied      - slot holds an unsent response (registered)
//   data          - stored payload (registered)
//   ovf_c         - combinational: strobe dropped this cycle
module tx_resp_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld,
    input  logic [W-1:0] data_in,
    input  logic         consume,
    output logic         occupied,
    output logic [W-1:0] data,
    output logic         ovf_c
);

    logic         occ_q, occ_d;
    logic [W-1:0] data_q, data_d;

    // A strobe is accepted when the slot is empty or being drained this cycle.
    always_comb begin
        occ_d  = occ_q;
        data_d = data_q;
        ovf_c  = 1'b0;
        if (consume) begin
            occ_d = 1'b0;
        end
        if (vld) begin
            if (!occ_q || consume) begin
                occ_d  = 1'b1;
                data_d = data_in;
            end else begin
                ovf_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= 1'b0;
            data_q <= '0;
        end else begin
            occ_q  <= occ_d;
            data_q <= data_d;
        end
    end

    assign occupied = occ_q;
    assign data     = data_q;

endmodule

// File: rtl/tx_resp_sched.sv
// Schedules register-file and ALU responses onto a UART TX byte interface.
// Round-robin between the two sources, one-cycle TX_D_VLD per byte, and a
// re-issue of the byte if TX_Busy never rises within TMO_CYCLES.
// Macro TX_ALU_HIGH_BYTE_EN: two-byte ALU responses (low byte first).
// Ports:
//   CLK, RST                - clock, async active-high reset
//   RdData, RdData_Valid    - register-file response and strobe
//   ALU_OUT, ALU_Valid      - ALU response and strobe
//   TX_Busy                 - UART frame in progress
//   TX_P_Data, TX_D_VLD     - byte to send and its one-cycle strobe
//   Ovf_Err                 - sticky: a response was dropped
module tx_resp_sched
    import tx_resp_sched_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RdData,
    input  logic        RdData_Valid,
    input  logic [15:0] ALU_OUT,
    input  logic        ALU_Valid,
    input  logic        TX_Busy,
    output logic [7:0]  TX_P_Data,
    output logic        TX_D_VLD,
    output logic        Ovf_Err
);

    localparam int unsigned CNT_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

    state_e                  state_q, state_d;
    src_e                    rr_q, rr_d;
    resp_t                   resp_q, resp_d;
    logic                    hi_q, hi_d;
    logic [CNT_W-1:0]        tmo_q, tmo_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_vld_q, tx_vld_d;
    logic                    ovf_q, ovf_d;

    logic                    rf_occ, alu_occ;
    logic [RF_SLOT_W-1:0]    rf_data;
    logic [ALU_SLOT_W-1:0]   alu_data;
    logic                    rf_ovf_c, alu_ovf_c;
    logic                    consume_rf, consume_alu;
    src_e                    grant_src;
    logic [15:0]             grant_data;

    tx_resp_slot #(.W(RF_SLOT_W)) u_rf_slot (
        .clk      (CLK),
        .rst      (RST),
        .vld      (RdData_Valid),
        .data_in  (RdData),
        .consume  (consume_rf),
        .occupied (rf_occ),
        .data     (rf_data),
        .ovf_c    (rf_ovf_c)
    );

    tx_resp_slot #(.W(ALU_SLOT_W)) u_alu_slot (
        .clk      (CLK),
        .rst      (RST),
        .vld      (ALU_Valid),
        .data_in  (ALU_OUT[ALU_SLOT_W-1:0]),
        .consume  (consume_alu),
        .occupied (alu_occ),
        .data     (alu_data),
        .ovf_c    (alu_ovf_c)
    );

    // Arbiter: rr_q only matters (and only advances) when both slots compete.
    always_comb begin
        grant_src = SRC_RF;
        if (rf_occ && alu_occ) begin
            grant_src = rr_q;
        end else if (!rf_occ) begin
            grant_src = SRC_ALU;
        end
        grant_data = (grant_src == SRC_RF) ? 16'(rf_data) : 16'(alu_data);
    end

    // Next-state and registered-output logic; TX_D_VLD is set on LOAD entry.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        resp_d      = resp_q;
        hi_d        = hi_q;
        tmo_d       = tmo_q;
        tx_data_d   = tx_data_q;
        tx_vld_d    = 1'b0;
        ovf_d       = ovf_q | rf_ovf_c | alu_ovf_c;
        consume_rf  = 1'b0;
        consume_alu = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((rf_occ || alu_occ) && !TX_Busy) begin
                    consume_rf       = (grant_src == SRC_RF);
                    consume_alu      = (grant_src == SRC_ALU);
                    if (rf_occ && alu_occ) begin
                        rr_d = other_src(grant_src);
                    end
                    resp_d.data      = grant_data;
                    resp_d.two_byte  = ALU_TWO_BYTE && (grant_src == SRC_ALU);
                    hi_d             = 1'b0;
                    tx_data_d        = grant_data[7:0];
                    tx_vld_d         = 1'b1;
                    state_d          = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tmo_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (TX_Busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == CNT_W'(TMO_CYCLES - 1)) begin
                    // UART never took the byte: re-issue it unchanged.
                    tx_vld_d = 1'b1;
                    state_d  = ST_LOAD;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!TX_Busy) begin
                    if (resp_q.two_byte && !hi_q) begin
                        hi_d      = 1'b1;
                        tx_data_d = resp_q.data[15:8];
                        tx_vld_d  = 1'b1;
                        state_d   = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            rr_q      <= SRC_RF;
            resp_q    <= '0;
            hi_q      <= 1'b0;
            tmo_q     <= '0;
            tx_data_q <= 8'h00;
            tx_vld_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            resp_q    <= resp_d;
            hi_q      <= hi_d;
            tmo_q     <= tmo_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            ovf_q     <= ovf_d;
        end
    end

    assign TX_P_Data = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign Ovf_Err   = ovf_q;

endmodule

// File: tb/tb_tx_resp_sched.sv
// Directed bench for tx_resp_sched: a cycle table for the basic and
// round-robin flows, plus hand sequences for timeout re-issue, overflow,
// the two-byte ALU response and reset in the middle of a transfer.
module tb_tx_resp_sched;

    logic        CLK          = 1'b0;
    logic        RST          = 1'b1;
    logic [7:0]  RdData       = 8'h00;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT      = 16'h0000;
    logic        ALU_Valid    = 1'b0;
    logic        TX_Busy      = 1'b0;
    logic [7:0]  TX_P_Data;
    logic        TX_D_VLD;
    logic        Ovf_Err;

    int checks = 0;
    int errors = 0;

    tx_resp_sched #(.TMO_CYCLES(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .ALU_OUT      (ALU_OUT),
        .ALU_Valid    (ALU_Valid),
        .TX_Busy      (TX_Busy),
        .TX_P_Data    (TX_P_Data),
        .TX_D_VLD     (TX_D_VLD),
        .Ovf_Err      (Ovf_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [7:0]  rd;
        logic        av;
        logic [15:0] alu;
        logic        busy;
        logic        ev;
        logic [7:0]  ed;
        logic        eo;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic rv, input logic [7:0] rd,
                       input logic av, input logic [15:0] alu, input logic b,
                       input logic ev, input logic [7:0] ed, input logic eo);
        vec_t v;
        v.rst = r; v.rv = rv; v.rd = rd; v.av = av; v.alu = alu; v.busy = b;
        v.ev = ev; v.ed = ed; v.eo = eo;
        tbl.push_back(v);
    endtask

    // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic r, input logic rv, input logic [7:0] rd,
                        input logic av, input logic [15:0] alu, input logic b);
        @(negedge CLK);
        RST = r; RdData_Valid = rv; RdData = rd;
        ALU_Valid = av; ALU_OUT = alu; TX_Busy = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic ev,
                       input logic [7:0] ed, input logic eo);
        checks++;
        if (TX_D_VLD !== ev || TX_P_Data !== ed || Ovf_Err !== eo) begin
            errors++;
            $display("FAIL %s[%0d]: got vld=%b data=%h ovf=%b, want vld=%b data=%h ovf=%b",
                     nm, idx, TX_D_VLD, TX_P_Data, Ovf_Err, ev, ed, eo);
        end
    endtask

    // Idle cycle with a given TX_Busy level.
    task automatic idle(input logic b);
        step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, b);
    endtask

    initial begin
        // ---------------- table ----------------
        add(1,0,8'h00,0,16'h0000,0, 0,8'h00,0);
        // single RF byte, UART busy 3 cycles after the strobe
        add(0,1,8'h5A,0,16'h0000,0, 0,8'h00,0);
        add(0,0,8'h00,0,16'h0000,0, 1,8'h5A,0);
        add(0,0,8'h00,0,16'h0000,0, 0,8'h5A,0);
        add(0,0,8'h00,0,16'h0000,0, 0,8'h5A,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h5A,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h5A,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h5A,0);
        add(0,0,8'h00,0,16'h0000,0, 0,8'h5A,0);
        add(0,0,8'h00,0,16'h0000,0, 0,8'h5A,0);
        add(0,0,8'h00,0,16'h0000,0, 0,8'h5A,0);
        // reset, then simultaneous RF/ALU strobes twice
        add(1,0,8'h00,0,16'h0000,0, 0,8'h00,0);
        add(0,1,8'h11,1,16'h0022,0, 0,8'h00,0);
        add(0,0,8'h00,0,16'h0000,0, 1,8'h11,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h11,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h11,0);
        add(0,0,8'h00,0,16'h0000,0, 0,8'h11,0);
        add(0,0,8'h00,0,16'h0000,0, 1,8'h22,0);
        add(0,1,8'h11,1,16'h0022,1, 0,8'h22,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h22,0);
`ifdef TX_ALU_HIGH_BYTE_EN
        add(0,0,8'h00,0,16'h0000,0, 1,8'h00,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h00,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h00,0);
        add(0,0,8'h00,0,16'h0000,0, 0,8'h00,0);
`else
        add(0,0,8'h00,0,16'h0000,0, 0,8'h22,0);
`endif
        add(0,0,8'h00,0,16'h0000,0, 1,8'h22,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h22,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h22,0);
`ifdef TX_ALU_HIGH_BYTE_EN
        add(0,0,8'h00,0,16'h0000,0, 1,8'h00,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h00,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h00,0);
        add(0,0,8'h00,0,16'h0000,0, 0,8'h00,0);
`else
        add(0,0,8'h00,0,16'h0000,0, 0,8'h22,0);
`endif
        add(0,0,8'h00,0,16'h0000,0, 1,8'h11,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h11,0);
        add(0,0,8'h00,0,16'h0000,1, 0,8'h11,0);
        add(0,0,8'h00,0,16'h0000,0, 0,8'h11,0);
        add(0,0,8'h00,0,16'h0000,0, 0,8'h11,0);

        // reset is asserted from time 0
        #1;
        chk("por", 0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].rv, tbl[i].rd, tbl[i].av, tbl[i].alu, tbl[i].busy);
            chk("tbl", i, tbl[i].ev, tbl[i].ed, tbl[i].eo);
        end

        // ---------------- timeout re-issue, capture on consume ----------------
        step(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        chk("tmo_rst", 0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h77, 1'b0, 16'h0000, 1'b0);
        chk("tmo_strobe", 0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h78, 1'b0, 16'h0000, 1'b0);
        chk("tmo_first", 0, 1'b1, 8'h77, 1'b0);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 8; k++) begin
                idle(1'b0);
                chk("tmo_gap", p * 8 + k, 1'b0, 8'h77, 1'b0);
            end
            idle(1'b0);
            chk("tmo_repulse", p, 1'b1, 8'h77, 1'b0);
        end
        idle(1'b1);
        chk("tmo_wb", 0, 1'b0, 8'h77, 1'b0);
        idle(1'b1);
        chk("tmo_wd", 0, 1'b0, 8'h77, 1'b0);
        idle(1'b0);
        chk("tmo_idle", 0, 1'b0, 8'h77, 1'b0);
        idle(1'b0);
        chk("tmo_second", 0, 1'b1, 8'h78, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        chk("tmo_done", 0, 1'b0, 8'h78, 1'b0);

        // ---------------- overflow on occupied RF slot ----------------
        step(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1);
        chk("ovf_rst", 0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h11, 1'b0, 16'h0000, 1'b1);
        chk("ovf_first", 0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b0, 16'h0000, 1'b1);
        chk("ovf_set", 0, 1'b0, 8'h00, 1'b1);
        idle(1'b1);
        chk("ovf_hold", 0, 1'b0, 8'h00, 1'b1);
        idle(1'b0);
        chk("ovf_send", 0, 1'b1, 8'h11, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        chk("ovf_back", 0, 1'b0, 8'h11, 1'b1);
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            chk("ovf_no33", k, 1'b0, 8'h11, 1'b1);
        end

        // ---------------- ALU BEEF, then reset while waiting on UART ----------------
        step(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1);
        chk("alu_rst", 0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 16'hBEEF, 1'b1);
        chk("alu_strobe", 0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 16'h1111, 1'b1);
        chk("alu_ovf", 0, 1'b0, 8'h00, 1'b1);
        idle(1'b0);
        chk("alu_lo", 0, 1'b1, 8'hEF, 1'b1);
        idle(1'b1);
        chk("alu_wb", 0, 1'b0, 8'hEF, 1'b1);
        idle(1'b1);
        chk("alu_wd", 0, 1'b0, 8'hEF, 1'b1);
        idle(1'b1);
        chk("alu_wd_hold", 0, 1'b0, 8'hEF, 1'b1);
`ifdef TX_ALU_HIGH_BYTE_EN
        idle(1'b0);
        chk("alu_hi", 0, 1'b1, 8'hBE, 1'b1);
        idle(1'b1);
        chk("alu_hi_wb", 0, 1'b0, 8'hBE, 1'b1);
        idle(1'b1);
        chk("alu_hi_wd", 0, 1'b0, 8'hBE, 1'b1);
`else
        idle(1'b0);
        chk("alu_no_hi", 0, 1'b0, 8'hEF, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b0);
        chk("alu2_strobe", 0, 1'b0, 8'hEF, 1'b1);
        idle(1'b0);
        chk("alu2_lo", 0, 1'b1, 8'h34, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("alu2_wd", 0, 1'b0, 8'h34, 1'b1);
`endif
        // asynchronous reset, away from any clock edge
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("async_rst", 0, 1'b0, 8'h00, 1'b0);
        @(posedge CLK);
        #1;
        chk("rst_held", 0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 12; k++) begin
            idle(1'b0);
            chk("post_rst", k, 1'b0, 8'h00, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_resp_sched.md
TX_RESP_SCHED -- requirements
Module: tx_resp_sched

Interface
REQ-001 SHALL have parameter TMO_CYCLES, default 8: cycles to wait in WAIT_BUSY for TX_Busy to rise before re-issuing the byte.
REQ-002 SHALL have port CLK, input, 1: single clock, rising edge.
REQ-003 SHALL have port RST, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port RdData, input, 8: register-file read data.
REQ-005 SHALL have port RdData_Valid, input, 1: one-cycle strobe qualifying RdData.
REQ-006 SHALL have port ALU_OUT, input, 16: ALU result.
REQ-007 SHALL have port ALU_Valid, input, 1: one-cycle strobe qualifying ALU_OUT.
REQ-008 SHALL have port TX_Busy, input, 1: UART TX frame in progress.
REQ-009 SHALL have port TX_P_Data, output, 8: byte to transmit.
REQ-010 SHALL have port TX_D_VLD, output, 1: one-cycle strobe qualifying TX_P_Data.
REQ-011 SHALL have port Ovf_Err, output, 1: sticky flag, response dropped.

Function
REQ-012 SHALL hold one pending slot per source (RF 8b, ALU 16b), each with an occupied bit set by its valid strobe.
REQ-013 SHALL drop a strobe that arrives while its own slot is occupied and not being consumed in that cycle, and SHALL set Ovf_Err.
REQ-014 SHALL capture a strobe arriving in the same cycle its slot is consumed, with no overflow.
REQ-015 SHALL use the FSM states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-016 IDLE: when any slot is occupied and TX_Busy=0, SHALL grant one slot and go to LOAD the next cycle; the granted slot's occupied bit clears on grant.
REQ-017 SHALL arbitrate round-robin: with both slots occupied, grant the source not granted last; after reset RF has priority.
REQ-018 LOAD: SHALL drive TX_P_Data with the current byte and TX_D_VLD=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-019 WAIT_BUSY: on TX_Busy=1 SHALL go to WAIT_DONE; after TMO_CYCLES cycles without it, SHALL return to LOAD and re-issue the same byte.
REQ-020 WAIT_DONE: on TX_Busy=0 SHALL go to LOAD if a byte of the granted response remains, else to IDLE.
REQ-021 The RF response SHALL be one byte; the ALU byte count SHALL be set by REQ-027.
REQ-022 TX_P_Data SHALL hold its last driven value outside LOAD; TX_D_VLD SHALL be 0 outside LOAD.
REQ-023 Grant-to-first-TX_D_VLD latency SHALL be 1 cycle; strobe-to-TX_D_VLD latency SHALL be 2 cycles from IDLE.

Reset
REQ-024 On RST=1 the block SHALL immediately force: state IDLE, both occupied bits 0, TX_D_VLD=0, TX_P_Data=8'h00, Ovf_Err=0, round-robin pointer to RF, timeout counter 0.
REQ-025 Reset mid-transfer SHALL abandon the response with no further TX_D_VLD.
REQ-026 Ovf_Err SHALL clear only on reset.

Configuration
REQ-027 With TX_ALU_HIGH_BYTE_EN defined, an ALU response SHALL be two bytes, ALU_OUT[7:0] then ALU_OUT[15:8]; undefined, it SHALL be one byte, ALU_OUT[7:0], and the upper slot bits SHALL not be stored.

Structure
REQ-028 A shared package SHALL hold the state enumeration, the source-select encoding (SRC_RF=0, SRC_ALU=1) and the TMO_CYCLES default.
REQ-029 A single sub-module, tx_resp_slot (occupied bit, data register, overflow detect), SHALL be instantiated once per source.

Verification
REQ-030 Single RF strobe RdData=8'h5A, TX_Busy high 3 cycles after TX_D_VLD: SHALL produce exactly one TX_D_VLD with 8'h5A, then IDLE.
REQ-031 ALU_OUT=16'hBEEF with TX_ALU_HIGH_BYTE_EN: SHALL send bytes EF then BE, the second only after TX_Busy falls; without the macro, only EF.
REQ-032 RF (8'h11) and ALU (16'h0022) strobes in the same cycle, then both again: SHALL send order 11, 22, then 22, 11.
REQ-033 Second RdData_Valid (8'h33) while the RF slot holds 8'h11 and TX_Busy=1: SHALL send 11 only and set Ovf_Err.
REQ-034 TX_Busy held 0 after LOAD: SHALL re-pulse TX_D_VLD with the same byte every TMO_CYCLES+1 cycles (every 9 by default).
REQ-035 RST pulse during WAIT_DONE of the ALU high byte: SHALL leave all outputs at reset values and give no TX_D_VLD until a new strobe.
